// File: rtl/f_part_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface f_part_if;
  logic [31:0] addr;
  logic        req;
  logic [31:0] rdata;
  logic        ready;

  modport master (output addr, output req, input rdata, input ready);
  modport slave  (input addr, input req, output rdata, output ready);
endinterface

// File: rtl/f_part.sv
// MIPS fetch stage: fetch PC register plus F/D pipeline register, with stall, exception and ERET redirects.
// Fetch address-error (AdEL) detection is built only when F_ADEL_CHECK_EN is defined.
module f_part #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        Stall,
  input  logic        IntExcReq,
  input  logic        isERET,
  input  logic        isBD,
  f_part_if.master    imem,
  output logic [31:0] F_PC,
  output logic        FetchStall,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic        adel_s;
  logic [31:0] fetch_word_s;
  logic [4:0]  fetch_code_s;
  logic        hold_s;

  // Address-error detection on the current fetch PC.
  always_comb begin
`ifdef F_ADEL_CHECK_EN
    adel_s = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);
`else
    adel_s = 1'b0;
`endif
  end

  // A faulting fetch becomes a nop tagged AdEL and never waits on memory.
  always_comb begin
    if (adel_s) begin
      fetch_word_s = 32'h0000_0000;
      fetch_code_s = EXC_ADEL;
    end else begin
      fetch_word_s = imem.rdata;
      fetch_code_s = EXC_NONE;
    end
  end

  assign imem.addr  = F_PC;
  assign imem.req   = ~adel_s;
  assign FetchStall = imem.req & ~imem.ready;
  assign hold_s     = Stall | FetchStall;

  // Fetch PC and F/D register update, in priority order exception > hold > eret > advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC      <= PC_RESET;
      D_Instr   <= 32'h0000_0000;
      D_PC      <= 32'h0000_0000;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
    end else if (IntExcReq) begin
      F_PC      <= EXC_ENTRY;
      D_Instr   <= 32'h0000_0000;
      D_PC      <= 32'h0000_0000;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
    end else if (hold_s) begin
      F_PC      <= F_PC;
      D_Instr   <= D_Instr;
      D_PC      <= D_PC;
      D_ExcCode <= D_ExcCode;
      D_BD      <= D_BD;
    end else if (isERET) begin
      // eret has no delay slot: the word behind it is dropped while NPC carries EPC.
      F_PC      <= NPC;
      D_Instr   <= 32'h0000_0000;
      D_PC      <= 32'h0000_0000;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
    end else begin
      F_PC      <= NPC;
      D_Instr   <= fetch_word_s;
      D_PC      <= F_PC;
      D_ExcCode <= fetch_code_s;
      D_BD      <= isBD;
    end
  end

endmodule

// File: tb/tb_f_part.sv
// Directed self-checking bench for f_part; expectations for address errors depend on F_ADEL_CHECK_EN.
module tb_f_part;

`ifdef F_ADEL_CHECK_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] NPC;
  logic        Stall;
  logic        IntExcReq;
  logic        isERET;
  logic        isBD;
  logic [31:0] F_PC;
  logic        FetchStall;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int checks = 0;
  int errors = 0;

  f_part_if bus ();

  f_part dut (
    .clk       (clk),
    .reset     (reset),
    .NPC       (NPC),
    .Stall     (Stall),
    .IntExcReq (IntExcReq),
    .isERET    (isERET),
    .isBD      (isBD),
    .imem      (bus),
    .F_PC      (F_PC),
    .FetchStall(FetchStall),
    .D_Instr   (D_Instr),
    .D_PC      (D_PC),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents seen by the fetch port.
  always_comb begin
    case (bus.addr)
      32'h0000_3000: bus.rdata = 32'h2401_0001;
      32'h0000_3004: bus.rdata = 32'h2402_0002;
      32'h0000_3008: bus.rdata = 32'h1000_0003;
      default:       bus.rdata = {16'hDEAD, bus.addr[15:0]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] code, input logic bd);
    chk({tag, "_dpc"},   D_PC, pc);
    chk({tag, "_dinst"}, D_Instr, instr);
    chk({tag, "_dexc"},  {27'd0, D_ExcCode}, {27'd0, code});
    chk({tag, "_dbd"},   {31'd0, D_BD}, {31'd0, bd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; NPC = 32'h0000_3000; Stall = 1'b0; IntExcReq = 1'b0;
    isERET = 1'b0; isBD = 1'b0; bus.ready = 1'b1;

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_fpc", F_PC, 32'h0000_3000);
    chk_d("rst", 32'h0, 32'h0, 5'd0, 1'b0);
    chk("rst_fstall", {31'd0, FetchStall}, 32'd0);
    #5 reset = 1'b0;

    // sequential fetch
    NPC = 32'h0000_3004;
    #1;
    chk("f0_addr", bus.addr, 32'h0000_3000);
    chk("f0_req", {31'd0, bus.req}, 32'd1);
    tick();
    chk("f0_fpc", F_PC, 32'h0000_3004);
    chk_d("f0", 32'h0000_3000, 32'h2401_0001, 5'd0, 1'b0);

    // memory wait for three cycles
    NPC = 32'h0000_3008; bus.ready = 1'b0;
    #1;
    chk("w_fstall", {31'd0, FetchStall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_fpc", F_PC, 32'h0000_3004);
      chk("w_req", {31'd0, bus.req}, 32'd1);
      chk_d("w", 32'h0000_3000, 32'h2401_0001, 5'd0, 1'b0);
    end
    bus.ready = 1'b1;
    tick();
    chk("f1_fpc", F_PC, 32'h0000_3008);
    chk_d("f1", 32'h0000_3004, 32'h2402_0002, 5'd0, 1'b0);

    // delay slot in F while decode holds a branch
    isBD = 1'b1; NPC = 32'h0000_3040;
    tick();
    isBD = 1'b0;
    chk("bd_fpc", F_PC, 32'h0000_3040);
    chk_d("bd", 32'h0000_3008, 32'h1000_0003, 5'd0, 1'b1);

    // exception entry overrides stall and flushes the slot
    IntExcReq = 1'b1; Stall = 1'b1; isBD = 1'b1;
    tick();
    IntExcReq = 1'b0; Stall = 1'b0; isBD = 1'b0;
    chk("exc_fpc", F_PC, 32'h0000_4180);
    chk_d("exc", 32'h0, 32'h0, 5'd0, 1'b0);

    // fetch the handler's first word
    NPC = 32'h0000_4184;
    tick();
    chk("h_fpc", F_PC, 32'h0000_4184);
    chk_d("h", 32'h0000_4180, 32'hDEAD_4180, 5'd0, 1'b0);

    // eret held by stall, then applied
    Stall = 1'b1; isERET = 1'b1; NPC = 32'h0000_300C;
    tick();
    chk("eh_fpc", F_PC, 32'h0000_4184);
    chk_d("eh", 32'h0000_4180, 32'hDEAD_4180, 5'd0, 1'b0);
    Stall = 1'b0;
    tick();
    isERET = 1'b0;
    chk("er_fpc", F_PC, 32'h0000_300C);
    chk_d("er", 32'h0, 32'h0, 5'd0, 1'b0);

    // misaligned NPC
    NPC = 32'h0000_3002;
    tick();
    chk("m0_fpc", F_PC, 32'h0000_3002);
    chk_d("m0", 32'h0000_300C, 32'hDEAD_300C, 5'd0, 1'b0);
    chk("m_req", {31'd0, bus.req}, ADEL_ON ? 32'd0 : 32'd1);
    bus.ready = 1'b0;
    #1;
    chk("m_fstall", {31'd0, FetchStall}, ADEL_ON ? 32'd0 : 32'd1);
    bus.ready = 1'b1;
    NPC = 32'h0000_7000;
    tick();
    chk("m1_fpc", F_PC, 32'h0000_7000);
    chk_d("m1", 32'h0000_3002, ADEL_ON ? 32'h0 : 32'hDEAD_3002, ADEL_ON ? 5'd4 : 5'd0, 1'b0);
    chk("hi_req", {31'd0, bus.req}, ADEL_ON ? 32'd0 : 32'd1);

    // beyond the top of instruction memory, then the last legal word
    NPC = 32'h0000_6FFC;
    tick();
    chk_d("hi", 32'h0000_7000, ADEL_ON ? 32'h0 : 32'hDEAD_7000, ADEL_ON ? 5'd4 : 5'd0, 1'b0);
    chk("top_req", {31'd0, bus.req}, 32'd1);
    NPC = 32'h0000_7000;
    tick();
    chk_d("top", 32'h0000_6FFC, 32'hDEAD_6FFC, 5'd0, 1'b0);

    // reset in the middle of a memory wait
    NPC = 32'h0000_7004; bus.ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("rw_fpc", F_PC, 32'h0000_3000);
    chk_d("rw", 32'h0, 32'h0, 5'd0, 1'b0);
    chk("rw_fstall", {31'd0, FetchStall}, 32'd1);
    reset = 1'b0;
    bus.ready = 1'b1; NPC = 32'h0000_3004;
    tick();
    chk_d("post", 32'h0000_3000, 32'h2401_0001, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_part.md
# f_part

Fetch stage of the five-stage MIPS pipeline: the producer end of the F→D interface that the decode stage consumes. It owns the fetch PC register and the F/D pipeline register. It drives the instruction memory read port and accepts the next-PC from decode. It applies stall, exception-entry and ERET redirects, flags fetch address errors, and marks delay-slot instructions before handing Instr/PC/ExcCode/BD to decode.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, F_PC value after reset.
- EXC_ENTRY, 32'h0000_4180, handler address loaded on IntExcReq.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears/initialises all state immediately.
- NPC  in  32  next fetch PC computed by decode.
- Stall  in  1  hazard-unit freeze of F and D.
- IntExcReq  in  1  interrupt/exception taken this cycle.
- isERET  in  1  decode holds an eret.
- isBD  in  1  decode holds a branch or jump, so the instruction now in F is its delay slot.
- imem_addr  out  32  fetch address, equal to F_PC.
- imem_req  out  1  read request, 0 on address error.
- imem_rdata  in  32  instruction word for imem_addr, combinational.
- imem_ready  in  1  imem_rdata valid this cycle.
- F_PC  out  32  current fetch PC, used by decode for PC-relative targets.
- FetchStall  out  1  F waiting on memory; the hazard unit ORs this into Stall.
- D_Instr  out  32  instruction to decode.
- D_PC  out  32  PC of D_Instr.
- D_ExcCode  out  5  exception code carried with D_Instr: 0 = none, 4 = AdEL.
- D_BD  out  1  D_Instr is a delay-slot instruction.

## Operation
- State: F_PC register and F/D register {D_Instr, D_PC, D_ExcCode, D_BD}.
- AdEL condition: F_PC[1:0] != 0, or F_PC < IM_LO, or F_PC > IM_HI.
  - When AdEL is set: imem_req = 0, the fetched word is forced to 0 (nop), fetch code = 4, and the instruction counts as ready regardless of imem_ready.
- FetchStall = imem_req & ~imem_ready.
- Each rising edge applies the first matching rule:
  1. IntExcReq: F_PC <= EXC_ENTRY; F/D <= bubble. Overrides Stall, FetchStall and isERET.
  2. Stall | FetchStall: F_PC and F/D hold.
  3. isERET: F_PC <= NPC (decode supplies EPC); F/D <= bubble. The instruction after eret is discarded; eret has no delay slot.
  4. Otherwise:
     - F_PC <= NPC.
     - D_Instr <= fetched word.
     - D_PC <= F_PC.
     - D_ExcCode <= fetch code.
     - D_BD <= isBD.
- Bubble: Instr 0, PC 0, ExcCode 0, BD 0.
- Delay slot: the branch target reaches F_PC on the same edge the delay slot moves into D. D_BD travels with the slot so EPC can later be set to D_PC-4.
- NPC is used unmodified (no alignment fix-up). A misaligned NPC surfaces as AdEL on the next fetch.

## Timing
- Reset (asynchronous assert):
  - F_PC = PC_RESET.
  - D_Instr = 0, D_PC = 0, D_ExcCode = 0, D_BD = 0.
  - FetchStall follows the imem_ready combinational rule.
- Deassertion takes effect at the next edge.
- Latency: instruction at F_PC appears on D_* one edge after it is accepted (imem_ready=1, no stall).
- Memory may hold imem_ready low for any number of cycles. F_PC and imem_addr stay stable throughout, and imem_req stays asserted.
- Reset asserted mid-wait or mid-flush abandons the operation; no partial update.
- Simultaneous events:
  - IntExcReq + isBD: the slot is flushed and D_BD = 0.
  - Stall + isERET: hold; ERET is applied once Stall drops.

## Configuration
- F_ADEL_CHECK_EN defined: AdEL detection as above.
- F_ADEL_CHECK_EN undefined:
  - fetch code is always 0;
  - imem_req is constant 1;
  - the fetched word always comes from imem_rdata;
  - IM_LO/IM_HI are unused.

## Test plan
- Reset pulse mid-cycle → F_PC=0x3000, D_Instr=0, D_PC=0, D_ExcCode=0 immediately, without waiting for a clock edge.
- NPC=F_PC+4, imem_ready=1, words 0x24010001/0x24020002 → D_PC 0x3000 then 0x3004; D_Instr matches each word.
- imem_ready=0 for 3 cycles → FetchStall=1, F_PC fixed at 0x3004, D_* unchanged. Ready=1 → next edge loads the word at 0x3004.
- isBD=1 with F_PC=0x3008, NPC=0x3040 → D_PC=0x3008, D_BD=1, F_PC=0x3040.
- IntExcReq=1 together with Stall=1 → F_PC=0x4180, D_Instr=0, D_BD=0. Next: isERET=1, NPC=0x300C → F_PC=0x300C, D bubble.
- NPC=0x3002 (macro defined) → at F_PC=0x3002: imem_req=0, then D_ExcCode=4, D_Instr=0, D_PC=0x3002. Same NPC=0x7000 → AdEL. Macro undefined → D_ExcCode=0.
